// File: rtl/clk_disp_scan.sv
// rtl/clk_disp_scan.sv - digit scan counter, double-dabble BCD formatter and blinking digit bank
// Fields are snapshotted on the frame wrap, converted one at a time, then committed to the bank atomically.
module clk_disp_scan #(
  parameter int DIGITS    = 8,
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 250
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [5:0]                 mode,
  input  logic [2:0]                 alarm_mode,
  input  logic [10:0]                hour,
  input  logic [10:0]                minute,
  input  logic [10:0]                second,
  input  logic [10:0]                temp_hour,
  input  logic [10:0]                temp_minute,
  input  logic [10:0]                temp_second,
  input  logic [5:0]                 month,
  input  logic [10:0]                day,
  input  logic [10:0]                week,
  input  logic [15:0]                year,
  input  logic [DIGITS-1:0]          blink_mask,
  output logic [$clog2(DIGITS)-1:0]  light,
  output logic [3:0]                 num,
  output logic                       dot,
  output logic                       busy
);
  localparam int LW = $clog2(DIGITS);
  localparam int PW = $clog2(SCAN_DIV + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [3:0] C_DASH  = 4'd11;
  localparam logic [3:0] C_BLANK = 4'd12;
  localparam logic [DIGITS-1:0] SHOWN = DIGITS'(8'hFF);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_STORE, S_COMMIT} state_t;
  typedef enum logic [1:0] {K_BLANK, K_TIME, K_DATE, K_YEAR} kind_t;

  state_t            state_q, state_d;
  kind_t             kind_q, kind_d;
  logic [PW-1:0]     pre_q, pre_d;
  logic [LW-1:0]     light_q, light_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic              phase_q, phase_d;
  logic [2:0][15:0]  fld_q, fld_d;
  logic [10:0]       week_q, week_d;
  logic [1:0]        k_q, k_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [13:0]       sr_q, sr_d;
  logic [15:0]       bcd_q, bcd_d;
  logic [7:0][3:0]   stage_q, stage_d, bank_q, bank_d;
  logic              year_q, year_d;
  logic [3:0]        num_q, num_d;
  logic              dot_q, dot_d;

  logic              pre_tc, frame, last;
  logic [15:0]       cur, roc, yc;
  logic [3:0]        two_hi, two_lo;
  logic [2:0]        base3, base4;

  function automatic logic [15:0] add3(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++)
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    return r;
  endfunction

  // Leading-zero blanking over four digits; the ones digit is always shown.
  function automatic logic [15:0] blank4(input logic [15:0] b);
    logic [15:0] c;
    c[15:12] = (b[15:12] == 4'd0) ? C_BLANK : b[15:12];
    c[11:8]  = (b[15:8]  == 8'd0) ? C_BLANK : b[11:8];
    c[7:4]   = (b[15:4]  == 12'd0) ? C_BLANK : b[7:4];
    c[3:0]   = b[3:0];
    return c;
  endfunction

  always_comb begin
    pre_tc  = (pre_q == PW'(SCAN_DIV - 1));
    frame   = pre_tc && (light_q == LW'(DIGITS - 1));
    pre_d   = pre_tc ? '0 : pre_q + 1'b1;
    light_d = light_q;
    if (pre_tc) light_d = frame ? '0 : light_q + 1'b1;
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (frame) begin
      if (bcnt_q == BW'(BLINK_DIV - 1)) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    fld_d   = fld_q;
    week_d  = week_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    bcd_d   = bcd_q;
    stage_d = stage_q;
    bank_d  = bank_q;
    year_d  = year_q;
    cur     = fld_q[k_q];
    roc     = fld_q[0] - 16'd1911;
    two_hi  = (cur > 16'd99) ? C_DASH : bcd_q[7:4];
    two_lo  = (cur > 16'd99) ? C_DASH : bcd_q[3:0];
    base3   = {k_q, 1'b0} + {1'b0, k_q};
    base4   = {k_q[0], 2'b00};
    yc      = blank4(bcd_q);
    last    = (kind_q == K_TIME) ? (k_q == 2'd2) : (k_q == 2'd1);
    case (state_q)
      S_IDLE: if (frame) begin
        state_d = S_LOAD;
        k_d     = '0;
        stage_d = {8{C_BLANK}};
        week_d  = week;
        fld_d   = '0;
        kind_d  = K_BLANK;
        case (mode)
          6'd1, 6'd5: begin
            kind_d = K_TIME;
            if (mode == 6'd5 && alarm_mode != 3'd0) begin
              fld_d[0] = {5'd0, temp_hour};
              fld_d[1] = {5'd0, temp_minute};
              fld_d[2] = {5'd0, temp_second};
            end else begin
              fld_d[0] = {5'd0, hour};
              fld_d[1] = {5'd0, minute};
              fld_d[2] = {5'd0, second};
            end
          end
          6'd2: begin
            kind_d   = K_DATE;
            fld_d[0] = {10'd0, month};
            fld_d[1] = {5'd0, day};
          end
          6'd3: begin
            kind_d   = K_YEAR;
            fld_d[0] = year;
          end
          default: ;
        endcase
      end
      S_LOAD: begin
        sr_d    = (kind_q == K_YEAR && k_q == 2'd1) ? roc[13:0] : cur[13:0];
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        bcd_d = {add3(bcd_q) << 1} | {15'd0, sr_q[13]};
        sr_d  = sr_q << 1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd13) state_d = S_STORE;
      end
      S_STORE: begin
        case (kind_q)
          K_TIME, K_DATE: begin
            stage_d[base3]        = two_hi;
            stage_d[base3 + 3'd1] = two_lo;
            if (k_q != 2'd2) stage_d[base3 + 3'd2] = C_DASH;
            if (kind_q == K_DATE && k_q == 2'd1) begin
              stage_d[6] = C_DASH;
              stage_d[7] = (week_q <= 11'd9) ? week_q[3:0] : C_DASH;
            end
          end
          K_YEAR: begin
            // An out-of-range year dashes Y and leaves R blank, as does a pre-ROC year.
            if (fld_q[0] > 16'd9999)
              yc = (k_q == 2'd0) ? {4{C_DASH}} : {4{C_BLANK}};
            else if (k_q == 2'd1 && fld_q[0] <= 16'd1911)
              yc = {4{C_BLANK}};
            stage_d[base4]        = yc[15:12];
            stage_d[base4 + 3'd1] = yc[11:8];
            stage_d[base4 + 3'd2] = yc[7:4];
            stage_d[base4 + 3'd3] = yc[3:0];
          end
          default: ;
        endcase
        if (last) begin
          state_d = S_COMMIT;
        end else begin
          k_d     = k_q + 2'd1;
          state_d = S_LOAD;
        end
      end
      S_COMMIT: begin
        bank_d  = stage_q;
        year_d  = (kind_q == K_YEAR);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs look at next-state light and bank so they line up with light and a commit shows next cycle.
  always_comb begin
    num_d = C_BLANK;
    if (SHOWN[light_d] && !(blink_mask[light_d] && !phase_d)) num_d = bank_d[light_d[2:0]];
    dot_d = !(year_d && light_d == LW'(3));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      kind_q  <= K_BLANK;
      pre_q   <= '0;
      light_q <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b1;
      fld_q   <= '0;
      week_q  <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      sr_q    <= '0;
      bcd_q   <= '0;
      stage_q <= {8{C_BLANK}};
      bank_q  <= {8{C_BLANK}};
      year_q  <= 1'b0;
      num_q   <= C_BLANK;
      dot_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      pre_q   <= pre_d;
      light_q <= light_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      fld_q   <= fld_d;
      week_q  <= week_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      bcd_q   <= bcd_d;
      stage_q <= stage_d;
      bank_q  <= bank_d;
      year_q  <= year_d;
      num_q   <= num_d;
      dot_q   <= dot_d;
    end
  end

  assign light = light_q;
  assign num   = num_q;
  assign dot   = dot_q;
  assign busy  = (state_q != S_IDLE);
endmodule

// File: tb/tb_clk_disp_scan.sv
// tb/tb_clk_disp_scan.sv - directed self-checking bench for clk_disp_scan
// Second instance with DIGITS=10 covers the always-blank extra positions.
module tb_clk_disp_scan;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  mode;
  logic [2:0]  alarm_mode;
  logic [10:0] hour, minute, second, temp_hour, temp_minute, temp_second, day, week;
  logic [5:0]  month;
  logic [15:0] year;
  logic [7:0]  blink_mask;
  logic [9:0]  blink_mask2;
  logic [2:0]  light;
  logic [3:0]  num;
  logic        dot, busy;
  logic [3:0]  light2;
  logic [3:0]  num2;
  logic        dot2, busy2;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clk_disp_scan #(.DIGITS(8), .SCAN_DIV(8), .BLINK_DIV(2)) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .alarm_mode(alarm_mode),
    .hour(hour), .minute(minute), .second(second),
    .temp_hour(temp_hour), .temp_minute(temp_minute), .temp_second(temp_second),
    .month(month), .day(day), .week(week), .year(year), .blink_mask(blink_mask),
    .light(light), .num(num), .dot(dot), .busy(busy));

  clk_disp_scan #(.DIGITS(10), .SCAN_DIV(8), .BLINK_DIV(2)) u_dut10 (
    .clk(clk), .rst(rst), .mode(mode), .alarm_mode(alarm_mode),
    .hour(hour), .minute(minute), .second(second),
    .temp_hour(temp_hour), .temp_minute(temp_minute), .temp_second(temp_second),
    .month(month), .day(day), .week(week), .year(year), .blink_mask(blink_mask2),
    .light(light2), .num(num2), .dot(dot2), .busy(busy2));

  task automatic wait_busy(input logic lvl);
    int t;
    t = 0;
    while (busy !== lvl && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) begin
      checks++; errors++;
      $display("FAIL wait_busy timeout: busy=%b required %b", busy, lvl);
    end
  endtask

  task automatic run_conv(output int n);
    wait_busy(1'b0);
    wait_busy(1'b1);
    n = 0;
    while (busy === 1'b1 && n < 200) begin n++; @(negedge clk); end
  endtask

  task automatic wait_light(input int p);
    int t;
    t = 0;
    while (light !== 3'(p) && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin
      checks++; errors++;
      $display("FAIL wait_light timeout: light=%0d required %0d", light, p);
    end
  endtask

  task automatic capture(output logic [31:0] codes, output logic [7:0] dots);
    codes = '0;
    dots  = '0;
    for (int p = 0; p < 8; p++) begin
      wait_light(p);
      codes[4*(7-p) +: 4] = num;
      dots[p] = dot;
    end
  endtask

  task automatic set_time(input logic [5:0] m, input logic [10:0] h, input logic [10:0] mi, input logic [10:0] s);
    mode = m; hour = h; minute = mi; second = s;
  endtask

  task automatic test_reset();
    int n;
    logic [31:0] c;
    logic [7:0] d;
    set_time(6'd1, 11'd12, 11'd34, 11'd56);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (light !== 3'd0) begin errors++; $display("FAIL reset_light: got %0d exp 0", light); end
    checks++; if (num !== 4'd12) begin errors++; $display("FAIL reset_num: got %0d exp 12", num); end
    checks++; if (dot !== 1'b1) begin errors++; $display("FAIL reset_dot: got %b exp 1", dot); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    rst = 1'b0;
    wait_busy(1'b1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (light !== 3'd0) begin errors++; $display("FAIL midrst_light: got %0d exp 0", light); end
    checks++; if (num !== 4'd12) begin errors++; $display("FAIL midrst_num: got %0d exp 12", num); end
    checks++; if (dot !== 1'b1) begin errors++; $display("FAIL midrst_dot: got %b exp 1", dot); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b exp 0", busy); end
    rst = 1'b0;
    run_conv(n);
    checks++; if (n != 49) begin errors++; $display("FAIL after_rst_busy_len: got %0d exp 49", n); end
    capture(c, d);
    checks++; if (c !== 32'h12B34B56) begin errors++; $display("FAIL after_rst_codes: got %h exp 12b34b56", c); end
  endtask

  task automatic test_time();
    int n;
    logic [31:0] c;
    logic [7:0] d;
    logic [5:0]  m[3]  = '{6'd1, 6'd5, 6'd1};
    logic [10:0] h[3]  = '{11'd9, 11'd18, 11'd9};
    logic [10:0] mi[3] = '{11'd45, 11'd5, 11'd150};
    logic [10:0] s[3]  = '{11'd7, 11'd30, 11'd7};
    logic [31:0] e[3]  = '{32'h09B45B07, 32'h18B05B30, 32'h09BBBB07};
    alarm_mode = 3'd0;
    for (int i = 0; i < 3; i++) begin
      set_time(m[i], h[i], mi[i], s[i]);
      run_conv(n);
      checks++; if (n != 49) begin errors++; $display("FAIL time_busy_len[%0d]: got %0d exp 49", i, n); end
      capture(c, d);
      checks++; if (c !== e[i]) begin errors++; $display("FAIL time_codes[%0d]: got %h exp %h", i, c, e[i]); end
      checks++; if (d !== 8'hFF) begin errors++; $display("FAIL time_dots[%0d]: got %h exp ff", i, d); end
    end
  endtask

  task automatic test_alarm();
    int n;
    logic [31:0] c;
    logic [7:0] d;
    set_time(6'd5, 11'd9, 11'd45, 11'd7);
    alarm_mode = 3'd2; temp_hour = 11'd23; temp_minute = 11'd0; temp_second = 11'd59;
    run_conv(n);
    capture(c, d);
    checks++; if (c !== 32'h23B00B59) begin errors++; $display("FAIL alarm_codes: got %h exp 23b00b59", c); end
    alarm_mode = 3'd0;
  endtask

  task automatic test_year();
    int n;
    logic [31:0] c;
    logic [7:0] d;
    logic [15:0] y[6] = '{16'd2024, 16'd1911, 16'd7, 16'd12000, 16'd1912, 16'd9999};
    logic [31:0] e[6] = '{32'h2024C113, 32'h1911CCCC, 32'hCCC7CCCC, 32'hBBBBCCCC, 32'h1912CCC1, 32'h99998088};
    mode = 6'd3;
    for (int i = 0; i < 6; i++) begin
      year = y[i];
      run_conv(n);
      checks++; if (n != 33) begin errors++; $display("FAIL year_busy_len[%0d]: got %0d exp 33", i, n); end
      capture(c, d);
      checks++; if (c !== e[i]) begin errors++; $display("FAIL year_codes[%0d]: got %h exp %h", i, c, e[i]); end
      checks++; if (d !== 8'hF7) begin errors++; $display("FAIL year_dots[%0d]: got %h exp f7", i, d); end
    end
  endtask

  task automatic test_date();
    int n;
    logic [31:0] c;
    logic [7:0] d;
    logic [10:0] dy[4] = '{11'd31, 11'd120, 11'd31, 11'd31};
    logic [10:0] wk[4] = '{11'd3, 11'd3, 11'd10, 11'd9};
    logic [31:0] e[4]  = '{32'h12B31BB3, 32'h12BBBBB3, 32'h12B31BBB, 32'h12B31BB9};
    mode = 6'd2; month = 6'd12;
    for (int i = 0; i < 4; i++) begin
      day = dy[i]; week = wk[i];
      run_conv(n);
      checks++; if (n != 33) begin errors++; $display("FAIL date_busy_len[%0d]: got %0d exp 33", i, n); end
      capture(c, d);
      checks++; if (c !== e[i]) begin errors++; $display("FAIL date_codes[%0d]: got %h exp %h", i, c, e[i]); end
      checks++; if (d !== 8'hFF) begin errors++; $display("FAIL date_dots[%0d]: got %h exp ff", i, d); end
    end
  endtask

  task automatic test_blank();
    int n;
    logic [31:0] c;
    logic [7:0] d;
    logic [5:0] m[2] = '{6'd0, 6'd4};
    for (int i = 0; i < 2; i++) begin
      mode = m[i];
      run_conv(n);
      capture(c, d);
      checks++; if (c !== 32'hCCCCCCCC) begin errors++; $display("FAIL blank_codes[%0d]: got %h exp cccccccc", i, c); end
    end
  endtask

  task automatic test_blink();
    int n;
    logic [2:0] prev;
    logic vis;
    set_time(6'd1, 11'd9, 11'd45, 11'd7);
    blink_mask = 8'h03;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n = 0;
    prev = light;
    for (int cy = 0; cy < 800 && n < 10; cy++) begin
      @(negedge clk);
      if (light !== prev) begin
        if (light == 3'd0) n++;
        if (n >= 2 && n < 10) begin
          vis = ((n / 2) % 2) == 0;
          if (light == 3'd0) begin
            checks++;
            if (num !== (vis ? 4'd0 : 4'd12)) begin errors++; $display("FAIL blink_pos0 frame %0d: got %0d exp %0d", n, num, vis ? 0 : 12); end
          end else if (light == 3'd1) begin
            checks++;
            if (num !== (vis ? 4'd9 : 4'd12)) begin errors++; $display("FAIL blink_pos1 frame %0d: got %0d exp %0d", n, num, vis ? 9 : 12); end
          end else if (light == 3'd3) begin
            checks++;
            if (num !== 4'd4) begin errors++; $display("FAIL blink_pos3 frame %0d: got %0d exp 4", n, num); end
          end
        end
        prev = light;
      end
    end
    if (n < 10) begin checks++; errors++; $display("FAIL blink_frames timeout: got %0d exp 10", n); end
    blink_mask = 8'h00;
  endtask

  task automatic test_snapshot();
    int n;
    logic [31:0] c;
    logic [7:0] d;
    set_time(6'd1, 11'd9, 11'd45, 11'd7);
    run_conv(n);
    wait_busy(1'b0);
    wait_busy(1'b1);
    hour = 11'd10;
    wait_busy(1'b0);
    wait_light(0);
    checks++; if (num !== 4'd0) begin errors++; $display("FAIL snap_old_pos0: got %0d exp 0", num); end
    wait_light(1);
    checks++; if (num !== 4'd9) begin errors++; $display("FAIL snap_old_pos1: got %0d exp 9", num); end
    run_conv(n);
    capture(c, d);
    checks++; if (c !== 32'h10B45B07) begin errors++; $display("FAIL snap_new_codes: got %h exp 10b45b07", c); end
  endtask

  task automatic test_digits10();
    int t;
    repeat (200) @(negedge clk);
    t = 0;
    while (light2 !== 4'd9 && t < 200) begin @(negedge clk); t++; end
    checks++; if (num2 !== 4'd12) begin errors++; $display("FAIL d10_pos9: got %0d exp 12 (light %0d)", num2, light2); end
    t = 0;
    while (light2 === 4'd9 && t < 20) begin @(negedge clk); t++; end
    checks++; if (light2 !== 4'd0) begin errors++; $display("FAIL d10_wrap: got %0d exp 0", light2); end
    t = 0;
    while (light2 !== 4'd7 && t < 200) begin @(negedge clk); t++; end
    checks++; if (num2 !== 4'd7) begin errors++; $display("FAIL d10_pos7: got %0d exp 7", num2); end
    t = 0;
    while (light2 !== 4'd8 && t < 200) begin @(negedge clk); t++; end
    checks++; if (num2 !== 4'd12) begin errors++; $display("FAIL d10_pos8: got %0d exp 12 (light %0d)", num2, light2); end
  endtask

  initial begin
    mode = 6'd0; alarm_mode = 3'd0;
    hour = '0; minute = '0; second = '0;
    temp_hour = '0; temp_minute = '0; temp_second = '0;
    month = '0; day = '0; week = '0; year = '0;
    blink_mask = 8'h00; blink_mask2 = 10'h000;
    test_reset();
    test_time();
    test_alarm();
    test_year();
    test_date();
    test_blank();
    test_blink();
    test_snapshot();
    test_digits10();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
